// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-time controller: BCD M:SS keypad entry, per-second countdown,
// pause/resume/cancel handling and a completion pulse plus timed beep.
module microwave_timer_ctrl #(
  parameter int unsigned BEEP_CYCLES = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       key_valid_i,
  input  logic [3:0] key_digit_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       door_closed_i,
  input  logic       sec_tick_i,
  output logic [3:0] min_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] sec_ones_o,
  output logic       mag_on_o,
  output logic       done_o,
  output logic       beep_o,
  output logic [2:0] state_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSet   = 3'd1;
  localparam logic [2:0] StCook  = 3'd2;
  localparam logic [2:0] StPause = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam int unsigned CntW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [CntW-1:0] BeepLoad = CntW'(BEEP_CYCLES - 1);

  logic [2:0]      state_q, state_d;
  logic [3:0]      min_q, min_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      ones_q, ones_d;
  logic            mag_on_q, mag_on_d;
  logic            done_q, done_d;
  logic            beep_q, beep_d;
  logic [CntW-1:0] beep_cnt_q, beep_cnt_d;

  logic            time_nonzero;
  logic            key_ok;
  logic [3:0]      dec_min, dec_tens, dec_ones;

  assign time_nonzero = (min_q != 4'd0) || (tens_q != 4'd0) || (ones_q != 4'd0);
  // Current ones digit moves into tens, so it must already be a legal tens value.
  assign key_ok       = (key_digit_i <= 4'd9) && (ones_q <= 4'd5);

  // BCD decrement of the displayed time with per-digit borrow.
  always_comb begin
    dec_min  = min_q;
    dec_tens = tens_q;
    dec_ones = ones_q;
    if (ones_q != 4'd0) begin
      dec_ones = ones_q - 4'd1;
    end else begin
      dec_ones = 4'd9;
      if (tens_q != 4'd0) begin
        dec_tens = tens_q - 4'd1;
      end else begin
        dec_tens = 4'd5;
        dec_min  = min_q - 4'd1;
      end
    end
  end

  // Next-state logic; the if/else chain encodes the event priority, and each
  // branch only fires when its event actually applies in the current state.
  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    beep_d     = beep_q;
    beep_cnt_d = beep_cnt_q;

    if (state_q == StDone) begin
      if (beep_cnt_q != '0) begin
        beep_cnt_d = beep_cnt_q - 1'b1;
      end else begin
        beep_d = 1'b0;
      end
    end

    if (!door_closed_i && (state_q == StCook)) begin
      state_d = StPause;
    end else if (stop_i && (state_q != StIdle)) begin
      state_d = StIdle;
      beep_d  = 1'b0;
      if (state_q == StCook) begin
        state_d = StPause;
      end else begin
        min_d  = 4'd0;
        tens_d = 4'd0;
        ones_d = 4'd0;
      end
    end else if (start_i && door_closed_i &&
                 (((state_q == StSet) && time_nonzero) || (state_q == StPause))) begin
      state_d = StCook;
    end else if (start_i && (state_q == StDone)) begin
      state_d = StIdle;
      beep_d  = 1'b0;
    end else if (key_valid_i && ((state_q == StIdle) || (state_q == StSet)) && key_ok) begin
      min_d   = tens_q;
      tens_d  = ones_q;
      ones_d  = key_digit_i;
      state_d = StSet;
    end else if (key_valid_i && (state_q == StDone)) begin
      state_d = StIdle;
      beep_d  = 1'b0;
    end else if (sec_tick_i && (state_q == StCook)) begin
      min_d  = dec_min;
      tens_d = dec_tens;
      ones_d = dec_ones;
      if ((dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0)) begin
        state_d    = StDone;
        beep_d     = 1'b1;
        beep_cnt_d = BeepLoad;
      end
    end

    if (state_q > StDone) begin
      state_d = StIdle;
    end
  end

  // Registered outputs derived from the next state.
  always_comb begin
    mag_on_d = (state_d == StCook);
    done_d   = (state_d == StDone) && (state_q != StDone);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      min_q      <= 4'd0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      mag_on_q   <= 1'b0;
      done_q     <= 1'b0;
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      mag_on_q   <= mag_on_d;
      done_q     <= done_d;
      beep_q     <= beep_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign min_o      = min_q;
  assign sec_tens_o = tens_q;
  assign sec_ones_o = ones_q;
  assign mag_on_o   = mag_on_q;
  assign done_o     = done_q;
  assign beep_o     = beep_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed table-driven bench for microwave_timer_ctrl plus hand-written
// sequences for completion/beep, door handling and reset mid-cook.
module tb_microwave_timer_ctrl;

  localparam int unsigned BeepCycles = 8;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic       sec_tick;
  logic [3:0] min_w, tens_w, ones_w;
  logic       mag_on_w, done_w, beep_w;
  logic [2:0] state_w;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic       rst;
    logic       kv;
    logic [3:0] kd;
    logic       st;
    logic       sp;
    logic       door;
    logic       tick;
    logic [3:0] e_min;
    logic [3:0] e_tens;
    logic [3:0] e_ones;
    logic       e_mag;
    logic       e_done;
    logic       e_beep;
    logic [2:0] e_state;
  } vec_t;

  vec_t vecs[$];

  microwave_timer_ctrl #(
    .BEEP_CYCLES(BeepCycles)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .key_valid_i  (key_valid),
    .key_digit_i  (key_digit),
    .start_i      (start),
    .stop_i       (stop),
    .door_closed_i(door_closed),
    .sec_tick_i   (sec_tick),
    .min_o        (min_w),
    .sec_tens_o   (tens_w),
    .sec_ones_o   (ones_w),
    .mag_on_o     (mag_on_w),
    .done_o       (done_w),
    .beep_o       (beep_w),
    .state_o      (state_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic kv, input logic [3:0] kd, input logic st,
                     input logic sp, input logic door, input logic tick,
                     input logic [3:0] m, input logic [3:0] t, input logic [3:0] o,
                     input logic mag, input logic dn, input logic bp, input logic [2:0] s);
    vec_t v;
    v = '{r, kv, kd, st, sp, door, tick, m, t, o, mag, dn, bp, s};
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, clock it in, then compare outputs 1 time unit later.
  task automatic step(input string name, input vec_t v);
    rst         = v.rst;
    key_valid   = v.kv;
    key_digit   = v.kd;
    start       = v.st;
    stop        = v.sp;
    door_closed = v.door;
    sec_tick    = v.tick;
    @(posedge clk);
    #1;
    tests_run++;
    if ({min_w, tens_w, ones_w, mag_on_w, done_w, beep_w, state_w} !==
        {v.e_min, v.e_tens, v.e_ones, v.e_mag, v.e_done, v.e_beep, v.e_state}) begin
      tests_failed++;
      $display("FAIL %s: got %0d:%0d%0d mag=%b done=%b beep=%b state=%0d, want %0d:%0d%0d mag=%b done=%b beep=%b state=%0d",
               name, min_w, tens_w, ones_w, mag_on_w, done_w, beep_w, state_w,
               v.e_min, v.e_tens, v.e_ones, v.e_mag, v.e_done, v.e_beep, v.e_state);
    end
  endtask

  // Shorthand for a hand sequence step.
  task automatic hs(input string name, input logic r, input logic kv, input logic [3:0] kd,
                    input logic st, input logic sp, input logic door, input logic tick,
                    input logic [3:0] m, input logic [3:0] t, input logic [3:0] o,
                    input logic mag, input logic dn, input logic bp, input logic [2:0] s);
    vec_t v;
    v = '{r, kv, kd, st, sp, door, tick, m, t, o, mag, dn, bp, s};
    step(name, v);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0; stop = 1'b0;
    door_closed = 1'b1; sec_tick = 1'b0;

    //   rst kv kd   st sp dr tk   min tens ones mag dn bp state
    add(1, 0, 0,   0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);  // reset
    add(0, 1, 1,   0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 1);  // key 1
    add(0, 1, 3,   0, 0, 1, 0,   0, 1, 3, 0, 0, 0, 1);  // key 3
    add(0, 1, 0,   0, 0, 1, 0,   1, 3, 0, 0, 0, 0, 1);  // key 0 -> 1:30
    add(0, 0, 0,   1, 0, 1, 0,   1, 3, 0, 1, 0, 0, 2);  // start -> COOK
    add(0, 0, 0,   0, 0, 1, 1,   1, 2, 9, 1, 0, 0, 2);  // tick -> 1:29
    add(1, 0, 0,   0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1,   0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 1);
    add(0, 1, 0,   0, 0, 1, 0,   0, 1, 0, 0, 0, 0, 1);  // 0:10
    add(0, 0, 0,   0, 0, 1, 1,   0, 1, 0, 0, 0, 0, 1);  // tick in SET ignored
    add(0, 0, 0,   1, 0, 1, 0,   0, 1, 0, 1, 0, 0, 2);
    add(0, 0, 0,   0, 0, 1, 1,   0, 0, 9, 1, 0, 0, 2);  // 0:10 -> 0:09
    add(1, 0, 0,   0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1,   0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 1);
    add(0, 1, 0,   0, 0, 1, 0,   0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0,   0, 0, 1, 0,   1, 0, 0, 0, 0, 0, 1);  // 1:00
    add(0, 0, 0,   1, 0, 1, 0,   1, 0, 0, 1, 0, 0, 2);
    add(0, 0, 0,   0, 0, 1, 1,   0, 5, 9, 1, 0, 0, 2);  // 1:00 -> 0:59
    add(1, 0, 0,   0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 7,   0, 0, 1, 0,   0, 0, 7, 0, 0, 0, 1);  // key 7
    add(0, 1, 5,   0, 0, 1, 0,   0, 0, 7, 0, 0, 0, 1);  // key 5 rejected (ones>5)
    add(1, 0, 0,   0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 12,  0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);  // key 12 rejected
    add(0, 0, 0,   1, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);  // start in IDLE ignored
    add(0, 1, 5,   0, 0, 1, 0,   0, 0, 5, 0, 0, 0, 1);
    add(0, 0, 0,   1, 0, 1, 0,   0, 0, 5, 1, 0, 0, 2);
    add(0, 0, 0,   0, 1, 1, 0,   0, 0, 5, 0, 0, 0, 3);  // stop in COOK -> PAUSE
    add(0, 0, 0,   0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0);  // stop in PAUSE -> IDLE
    add(0, 1, 5,   0, 0, 1, 0,   0, 0, 5, 0, 0, 0, 1);
    add(0, 0, 0,   1, 0, 1, 0,   0, 0, 5, 1, 0, 0, 2);
    add(0, 0, 0,   0, 1, 1, 0,   0, 0, 5, 0, 0, 0, 3);
    add(0, 0, 0,   1, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0);  // stop+start in PAUSE -> IDLE
    add(0, 1, 0,   0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 1);  // key 0 -> SET at 0:00
    add(0, 0, 0,   1, 0, 1, 0,   0, 0, 0, 0, 0, 0, 1);  // start at 0:00 ignored
    add(0, 0, 0,   0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0);  // stop in SET -> IDLE

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Completion: 0:02, two ticks, done pulse and beep for BeepCycles cycles.
    hs("c_rst",   1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    hs("c_k0",    0, 1, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1);
    hs("c_k0b",   0, 1, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1);
    hs("c_k2",    0, 1, 2, 0, 0, 1, 0,  0, 0, 2, 0, 0, 0, 1);
    hs("c_start", 0, 0, 0, 1, 0, 1, 0,  0, 0, 2, 1, 0, 0, 2);
    hs("c_tick1", 0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 1, 0, 0, 2);
    hs("c_tick2", 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 1, 1, 4);
    for (int i = 1; i < 12; i++) begin
      hs($sformatf("c_done%0d", i), 0, 0, 0, 0, 0, 1, 0,
         0, 0, 0, 0, 0, (i < int'(BeepCycles)) ? 1'b1 : 1'b0, 4);
    end
    hs("c_keyout", 0, 1, 3, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);

    // Stop during beep clears it and returns to IDLE.
    hs("b_k1",    0, 1, 1, 0, 0, 1, 0,  0, 0, 1, 0, 0, 0, 1);
    hs("b_start", 0, 0, 0, 1, 0, 1, 0,  0, 0, 1, 1, 0, 0, 2);
    hs("b_tick",  0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 1, 1, 4);
    hs("b_hold",  0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1, 4);
    hs("b_stop",  0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0);

    // Door opening with a tick at 0:45, blocked start, then resume.
    hs("d_k4",     0, 1, 4, 0, 0, 1, 0,  0, 0, 4, 0, 0, 0, 1);
    hs("d_k5",     0, 1, 5, 0, 0, 1, 0,  0, 4, 5, 0, 0, 0, 1);
    hs("d_start",  0, 0, 0, 1, 0, 1, 0,  0, 4, 5, 1, 0, 0, 2);
    hs("d_open",   0, 0, 0, 0, 0, 0, 1,  0, 4, 5, 0, 0, 0, 3);
    hs("d_blk",    0, 0, 0, 1, 0, 0, 0,  0, 4, 5, 0, 0, 0, 3);
    hs("d_close",  0, 0, 0, 0, 0, 1, 0,  0, 4, 5, 0, 0, 0, 3);
    hs("d_resume", 0, 0, 0, 1, 0, 1, 0,  0, 4, 5, 1, 0, 0, 2);
    hs("d_tick",   0, 0, 0, 0, 0, 1, 1,  0, 4, 4, 1, 0, 0, 2);

    // Reset mid-cook at 3:17.
    hs("r_rst0",  1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    hs("r_k3",    0, 1, 3, 0, 0, 1, 0,  0, 0, 3, 0, 0, 0, 1);
    hs("r_k1",    0, 1, 1, 0, 0, 1, 0,  0, 3, 1, 0, 0, 0, 1);
    hs("r_k7",    0, 1, 7, 0, 0, 1, 0,  3, 1, 7, 0, 0, 0, 1);
    hs("r_start", 0, 0, 0, 1, 0, 1, 0,  3, 1, 7, 1, 0, 0, 2);
    hs("r_rst",   1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/microwave_timer_ctrl.md
# microwave_timer_ctrl

Cook-time controller for the microwave front panel. Accepts keypad digits into a three-digit BCD time (M:SS), counts it down one second per `sec_tick` while the door is closed and the magnetron is enabled, and handles pause, resume, cancel and completion. Its `min`, `sec_tens` and `sec_ones` outputs drive the `decoder` 7-segment block directly. A beep output follows each completed cook.

## Interface
- `BEEP_CYCLES`, default 8: clock cycles `beep` stays high after completion; legal range ≥1.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  one-cycle strobe, `key_digit` is valid.
- `key_digit`  in  4  keypad value; only values 0–9 are legal digits.
- `start`  in  1  start/resume button, one-cycle pulse.
- `stop`  in  1  stop/cancel button, one-cycle pulse.
- `door_closed`  in  1  level; 1 = door shut.
- `sec_tick`  in  1  one-cycle strobe, once per second.
- `min`  out  4  BCD minutes, 0–9.
- `sec_tens`  out  4  BCD tens of seconds, 0–5.
- `sec_ones`  out  4  BCD seconds, 0–9.
- `mag_on`  out  1  magnetron enable; high only in COOK.
- `done`  out  1  one-cycle pulse on completion.
- `beep`  out  1  buzzer enable.
- `state`  out  3  IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4.

## Operation
- Reset drives IDLE, all digits 0, and `mag_on`, `done`, `beep` 0.
- All outputs are registered. No combinational path runs from inputs to outputs.
- Per-cycle event priority: `door_closed`=0, then `stop`, then `start`, then `key_valid`, then `sec_tick`. Only the highest-priority applicable event acts in a cycle.
- Key entry is legal in IDLE and SET.
  - The digit shifts in from the right: `min`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`key_digit`. State becomes SET.
  - The key is rejected (no change) if `key_digit`>9 or the current `sec_ones`>5, because that value would become an illegal `sec_tens`.
  - `key_valid` in COOK, PAUSE or DONE is ignored, except that in DONE it returns the block to IDLE.
- `start`:
  - In SET with time ≠0:00 and door closed: go to COOK.
  - In PAUSE with door closed: go to COOK.
  - Otherwise ignored, including in IDLE and in SET with time 0:00.
- `stop`:
  - In COOK: go to PAUSE, time held.
  - In SET or PAUSE: go to IDLE, digits cleared to 0.
  - In DONE: go to IDLE.
- Door open (`door_closed`=0):
  - In COOK: go to PAUSE.
  - In any other state: no state change, and `start` is blocked.
- `sec_tick` in COOK decrements the time in BCD.
  - `sec_ones` 0 wraps to 9 and borrows.
  - `sec_tens` 0 wraps to 5 and borrows.
  - `min` decrements.
  - If the result is 0:00, the same edge moves to DONE.
- `sec_tick` outside COOK is ignored.
- DONE behaviour:
  - Display is 0:00.
  - `done` is high for exactly the first cycle in DONE.
  - `beep` is high for BEEP_CYCLES cycles from DONE entry.
  - Any `key_valid`, `start` or `stop` returns to IDLE and clears `beep` on that edge. Otherwise DONE holds after the beep ends.

## Timing
- `mag_on` rises on the same edge that enters COOK, one cycle after the `start` pulse is sampled. It falls on the edge that leaves COOK.
- Decrement latency: the new time is visible one cycle after `sec_tick` is sampled.
- Completion: on the edge sampling `sec_tick` at 0:01, the digits become 0:00, `state` becomes DONE, and `mag_on`, `done` and `beep` change together.
- Door opening and `sec_tick` in the same cycle: go to PAUSE with no decrement.
- `stop` and `start` in the same cycle: `stop` wins.
- `rst` asserted in any state, including mid-COOK: IDLE and 0:00 on the next edge, and `mag_on` drops on that edge.
- Maximum settable time is 9:59. No upper-limit logic beyond the per-digit rules above.

## Test plan
- Keys 1,3,0 then `start` → 1:30 and SET, then COOK with `mag_on`=1 one cycle later. After 1 tick the display shows 1:29. Ticks at 1:00 → 0:59 and at 0:10 → 0:09.
- Keys 0,0,2 then start, then 2 ticks → 0:01, then 0:00 with DONE, a 1-cycle `done` pulse, and `beep` high for 8 cycles (BEEP_CYCLES=8). `mag_on` falls on the same edge as DONE entry.
- During COOK at 0:45, drop `door_closed` in the same cycle as `sec_tick` → PAUSE, time stays 0:45, `mag_on`=0. A `start` while the door is open is ignored. Close the door, then `start` → COOK.
- Key 7 then key 5 → second key rejected, display stays 0:07. Key 12 → ignored. `start` in IDLE at 0:00 → stays IDLE.
- In COOK, `stop` → PAUSE. A second `stop` → IDLE at 0:00. `stop` and `start` in the same cycle in PAUSE → IDLE.
- Assert `rst` mid-COOK at 3:17 → next edge gives IDLE, 0:00, `mag_on`=0, `beep`=0, `done`=0.
